// File: rtl/beeth9_pkg.sv
// Shared Beeth9 definitions: instruction memory geometry and the loader state encoding.
package beeth9_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 9;

    typedef enum logic [2:0] {
        S_COUNT,
        S_BASE,
        S_LO,
        S_HI,
        S_WRITE,
        S_CSUM,
        S_LAUNCH,
        S_RUN
    } loader_state_t;

    // States in which the loader takes a byte from the host.
    function automatic logic rxReadyIn(loader_state_t s);
        return s inside {S_COUNT, S_BASE, S_LO, S_HI, S_CSUM};
    endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Loader bundle: host byte stream, instruction memory write port and core start/done control.
interface instr_loader_if;
    import beeth9_pkg::*;

    logic [7:0]         Rx_Data;
    logic               Rx_Valid;
    logic               Rx_Ready;
    logic               IMem_WrEn;
    logic [ADDR_W-1:0]  IMem_WrAddr;
    logic [INSTR_W-1:0] IMem_WrData;
    logic               Start;
    logic [ADDR_W-1:0]  Start_Addr;
    logic               Core_Done;
    logic               Busy;
    logic               Err;

    // Loader side.
    modport master (
        input  Rx_Data, Rx_Valid, Core_Done,
        output Rx_Ready, IMem_WrEn, IMem_WrAddr, IMem_WrData,
               Start, Start_Addr, Busy, Err
    );

    // Host / memory / core side.
    modport slave (
        output Rx_Data, Rx_Valid, Core_Done,
        input  Rx_Ready, IMem_WrEn, IMem_WrAddr, IMem_WrData,
               Start, Start_Addr, Busy, Err
    );

endinterface

// File: rtl/instr_loader.sv
// Beeth9 instruction loader: packs host byte pairs into 9-bit words, writes the ROM, then launches the core.
// Optional trailing-XOR stream check is enabled by defining CHECKSUM_EN.
module instr_loader
    import beeth9_pkg::*;
#(
    parameter int START_CYCLES = 2
) (
    input  logic           CLK,
    input  logic           Reset_n,
    instr_loader_if.master bus
);

    localparam int CNT_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
`ifdef CHECKSUM_EN
    localparam loader_state_t AFTER_LOAD = S_CSUM;
`else
    localparam loader_state_t AFTER_LOAD = S_LAUNCH;
`endif

    loader_state_t     state, nextState;
    logic              accept;
    logic [7:0]        remaining;
    logic [7:0]        loByte;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  startCnt;

    assign accept = bus.Rx_Valid && bus.Rx_Ready;

`ifdef CHECKSUM_EN
    logic [7:0] csum;
    logic       csumOk;

    assign csumOk = (csum == bus.Rx_Data);
`endif

    // NOTE: nextState gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        nextState = state;
        case (state)
            S_COUNT:  if (accept) nextState = S_BASE;
            S_BASE:   if (accept) nextState = (remaining != 8'd0) ? S_LO : AFTER_LOAD;
            S_LO:     if (accept) nextState = S_HI;
            S_HI:     if (accept) nextState = S_WRITE;
            S_WRITE:  nextState = (remaining == 8'd1) ? AFTER_LOAD : S_LO;
`ifdef CHECKSUM_EN
            S_CSUM:   if (accept) nextState = csumOk ? S_LAUNCH : S_COUNT;
`endif
            S_LAUNCH: if (startCnt == '0) nextState = S_RUN;
            S_RUN:    if (bus.Core_Done) nextState = S_COUNT;
            default:  nextState = S_COUNT;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) state <= S_COUNT;
        else          state <= nextState;
    end

    // Status outputs are registered from nextState so they line up with the state they describe.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Rx_Ready    <= 1'b1;
            bus.IMem_WrEn   <= 1'b0;
            bus.IMem_WrAddr <= '0;
            bus.IMem_WrData <= '0;
            bus.Start       <= 1'b1;
            bus.Start_Addr  <= '0;
            bus.Busy        <= 1'b0;
            remaining       <= '0;
            loByte          <= '0;
            addr            <= '0;
            startCnt        <= '0;
        end else begin
            bus.Rx_Ready  <= rxReadyIn(nextState);
            bus.Busy      <= (nextState != S_COUNT);
            bus.Start     <= (nextState != S_RUN);
            bus.IMem_WrEn <= 1'b0;

            case (state)
                S_COUNT: if (accept) remaining <= bus.Rx_Data;
                S_BASE: if (accept) begin
                    bus.Start_Addr <= bus.Rx_Data;
                    addr           <= bus.Rx_Data;
                end
                S_LO: if (accept) loByte <= bus.Rx_Data;
                S_HI: if (accept) begin
                    bus.IMem_WrData <= {bus.Rx_Data[0], loByte};
                    bus.IMem_WrAddr <= addr;
                    bus.IMem_WrEn   <= 1'b1;
                end
                S_WRITE: begin
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                S_LAUNCH: if (startCnt != '0) startCnt <= startCnt - 1'b1;
                default: ;
            endcase

            // Arm the hold counter on entry so Start stays high for exactly START_CYCLES launch cycles.
            if (nextState == S_LAUNCH && state != S_LAUNCH)
                startCnt <= CNT_W'(START_CYCLES - 1);
        end
    end

`ifdef CHECKSUM_EN
    // Running XOR restarts on the COUNT byte; Err is re-evaluated on every checksum byte.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            csum    <= '0;
            bus.Err <= 1'b0;
        end else if (accept) begin
            csum <= (state == S_COUNT) ? bus.Rx_Data : (csum ^ bus.Rx_Data);
            if (state == S_CSUM) bus.Err <= !csumOk;
        end
    end
`else
    assign bus.Err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed self-checking bench for instr_loader; builds with or without CHECKSUM_EN.
module tb_instr_loader;
    import beeth9_pkg::*;

    localparam int START_CYCLES = 2;

    typedef struct packed {
        logic [7:0] addr;
        logic [8:0] data;
    } wr_t;

    logic CLK = 1'b0;
    logic Reset_n = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    wr_t  wrLog[$];

    instr_loader_if bus();

    instr_loader #(.START_CYCLES(START_CYCLES)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    // Every cycle with the strobe high is one memory write.
    always @(negedge CLK)
        if (bus.IMem_WrEn === 1'b1) wrLog.push_back({bus.IMem_WrAddr, bus.IMem_WrData});

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        bus.Rx_Data  = b;
        bus.Rx_Valid = 1'b1;
        while (bus.Rx_Ready !== 1'b1 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 100) begin
            compared++; mismatched++;
            $display("FAIL send_byte_timeout: Rx_Ready=%b required 1 for byte %h", bus.Rx_Ready, b);
        end
        @(negedge CLK);
        bus.Rx_Valid = 1'b0;
    endtask

    // Sends a stream; with CHECKSUM_EN the XOR trailer is appended.
    task automatic send_stream(input logic [7:0] s[$], input bit gaps);
        logic [7:0] x;
        x = 8'h00;
        foreach (s[i]) begin
            x ^= s[i];
            if (gaps && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge CLK);
            end
            send_byte(s[i]);
        end
`ifdef CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_launch();
        int w;
        w = 0;
        while (bus.Start !== 1'b0 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        if (w >= 100) begin
            compared++; mismatched++;
            $display("FAIL launch_timeout: Start=%b required 0", bus.Start);
        end
    endtask

    task automatic pulse_done();
        bus.Core_Done = 1'b1;
        @(negedge CLK);
        bus.Core_Done = 1'b0;
    endtask

    task automatic test_reset();
        bus.Rx_Data = 8'h00; bus.Rx_Valid = 1'b0; bus.Core_Done = 1'b0;
        #2 Reset_n = 1'b0;
        repeat (3) @(negedge CLK);
        compared++;
        if ({bus.Start, bus.Rx_Ready, bus.Busy, bus.IMem_WrEn, bus.Err} !== 5'b11000) begin
            mismatched++;
            $display("FAIL reset_flags: Start,Ready,Busy,WrEn,Err=%b required 11000",
                     {bus.Start, bus.Rx_Ready, bus.Busy, bus.IMem_WrEn, bus.Err});
        end
        compared++;
        if ({bus.Start_Addr, bus.IMem_WrAddr, bus.IMem_WrData} !== 25'h0) begin
            mismatched++;
            $display("FAIL reset_values: Start_Addr=%h WrAddr=%h WrData=%h required 0",
                     bus.Start_Addr, bus.IMem_WrAddr, bus.IMem_WrData);
        end
        Reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        compared++;
        if ({bus.Start, bus.Rx_Ready, bus.Busy} !== 3'b110) begin
            mismatched++;
            $display("FAIL reset_idle: Start,Ready,Busy=%b required 110", {bus.Start, bus.Rx_Ready, bus.Busy});
        end
    endtask

    task automatic test_basic();
        logic [7:0] s[$];
        wr_t exp[2];
        exp[0] = {8'h10, 9'h103};
        exp[1] = {8'h11, 9'h0AB};
        wrLog.delete();
        s = {8'h02, 8'h10, 8'h03, 8'h01, 8'hAB, 8'h00};
        send_stream(s, 1'b0);
`ifndef CHECKSUM_EN
        compared++;
        if ({bus.IMem_WrEn, bus.IMem_WrAddr, bus.IMem_WrData} !== {1'b1, 8'h11, 9'h0AB}) begin
            mismatched++;
            $display("FAIL basic_write_latency: WrEn=%b addr=%h data=%h required 1/11/0ab",
                     bus.IMem_WrEn, bus.IMem_WrAddr, bus.IMem_WrData);
        end
        @(negedge CLK);
`endif
        for (int k = 0; k < START_CYCLES; k++) begin
            compared++;
            if (bus.Start !== 1'b1 || bus.IMem_WrEn !== 1'b0) begin
                mismatched++;
                $display("FAIL basic_start_hold[%0d]: Start=%b WrEn=%b required 1/0", k, bus.Start, bus.IMem_WrEn);
            end
            @(negedge CLK);
        end
        compared++;
        if ({bus.Start, bus.Busy, bus.Rx_Ready, bus.Start_Addr} !== {3'b010, 8'h10}) begin
            mismatched++;
            $display("FAIL basic_release: Start=%b Busy=%b Ready=%b Start_Addr=%h required 0/1/0/10",
                     bus.Start, bus.Busy, bus.Rx_Ready, bus.Start_Addr);
        end
        compared++;
        if (wrLog.size() != 2) begin
            mismatched++;
            $display("FAIL basic_write_count: got %0d required 2", wrLog.size());
        end
        for (int i = 0; i < 2 && i < wrLog.size(); i++) begin
            compared++;
            if (wrLog[i] !== exp[i]) begin
                mismatched++;
                $display("FAIL basic_write[%0d]: got %h@%h required %h@%h", i,
                         wrLog[i].data, wrLog[i].addr, exp[i].data, exp[i].addr);
            end
        end
        pulse_done();
        compared++;
        if ({bus.Start, bus.Busy, bus.Rx_Ready} !== 3'b101) begin
            mismatched++;
            $display("FAIL basic_done: Start,Busy,Ready=%b required 101", {bus.Start, bus.Busy, bus.Rx_Ready});
        end
    endtask

    task automatic test_wrap();
        logic [7:0] s[$];
        wr_t exp[2];
        exp[0] = {8'hFF, 9'h011};
        exp[1] = {8'h00, 9'h122};
        wrLog.delete();
        s = {8'h02, 8'hFF, 8'h11, 8'h00, 8'h22, 8'h01};
        send_stream(s, 1'b0);
        wait_launch();
        compared++;
        if (wrLog.size() != 2) begin
            mismatched++;
            $display("FAIL wrap_write_count: got %0d required 2", wrLog.size());
        end
        for (int i = 0; i < 2 && i < wrLog.size(); i++) begin
            compared++;
            if (wrLog[i] !== exp[i]) begin
                mismatched++;
                $display("FAIL wrap_write[%0d]: got %h@%h required %h@%h", i,
                         wrLog[i].data, wrLog[i].addr, exp[i].data, exp[i].addr);
            end
        end
        pulse_done();
    endtask

    // Same payload twice: Rx_Valid continuously held, then with random idle gaps.
    task automatic test_back_to_back();
        logic [7:0] s[$];
        logic [7:0] base[2];
        logic [8:0] expData[4];
        expData[0] = 9'h001; expData[1] = 9'h102; expData[2] = 9'h003; expData[3] = 9'h1FF;
        base[0] = 8'h30; base[1] = 8'h50;
        for (int r = 0; r < 2; r++) begin
            wrLog.delete();
            s = {8'h04, base[r], 8'h01, 8'h00, 8'h02, 8'h01, 8'h03, 8'hFE, 8'hFF, 8'hFF};
            send_stream(s, r == 1);
            wait_launch();
            compared++;
            if (wrLog.size() != 4) begin
                mismatched++;
                $display("FAIL b2b_write_count[%0d]: got %0d required 4", r, wrLog.size());
            end
            for (int i = 0; i < 4 && i < wrLog.size(); i++) begin
                compared++;
                if (wrLog[i] !== {base[r] + 8'(i), expData[i]}) begin
                    mismatched++;
                    $display("FAIL b2b_write[%0d][%0d]: got %h@%h required %h@%h", r, i,
                             wrLog[i].data, wrLog[i].addr, expData[i], base[r] + 8'(i));
                end
            end
            pulse_done();
        end
    endtask

    // A byte offered while the core runs is held off, then taken as the next COUNT (N=0 program).
    task automatic test_held_zero();
        logic [7:0] s[$];
        wrLog.delete();
        s = {8'h01, 8'h80, 8'h7F, 8'h01};
        send_stream(s, 1'b0);
        wait_launch();
        bus.Rx_Data  = 8'h00;
        bus.Rx_Valid = 1'b1;
        repeat (4) @(negedge CLK);
        compared++;
        if ({bus.Rx_Ready, bus.Start, bus.Busy} !== 3'b001) begin
            mismatched++;
            $display("FAIL held_in_run: Ready,Start,Busy=%b required 001", {bus.Rx_Ready, bus.Start, bus.Busy});
        end
        pulse_done();
        compared++;
        if ({bus.Rx_Ready, bus.Start, bus.Busy} !== 3'b110) begin
            mismatched++;
            $display("FAIL held_after_done: Ready,Start,Busy=%b required 110", {bus.Rx_Ready, bus.Start, bus.Busy});
        end
        @(negedge CLK);
        bus.Rx_Valid = 1'b0;
        compared++;
        if ({bus.Start, bus.Busy} !== 2'b11) begin
            mismatched++;
            $display("FAIL held_count_taken: Start,Busy=%b required 11", {bus.Start, bus.Busy});
        end
        send_byte(8'h40);
`ifdef CHECKSUM_EN
        send_byte(8'h40);
`endif
        wait_launch();
        compared++;
        if (bus.Start_Addr !== 8'h40) begin
            mismatched++;
            $display("FAIL zero_start_addr: got %h required 40", bus.Start_Addr);
        end
        compared++;
        if (wrLog.size() != 1 || wrLog[0] !== {8'h80, 9'h17F}) begin
            mismatched++;
            $display("FAIL zero_no_writes: log size %0d required 1 (17f@80 only)", wrLog.size());
        end
        pulse_done();
    endtask

    task automatic test_reset_mid();
        wrLog.delete();
        send_byte(8'h03); send_byte(8'h60); send_byte(8'h05); send_byte(8'h01);
        @(negedge CLK);
        #2 Reset_n = 1'b0;
        #1;
        compared++;
        if ({bus.Start, bus.Rx_Ready, bus.Busy, bus.IMem_WrEn} !== 4'b1100) begin
            mismatched++;
            $display("FAIL midreset_async: Start,Ready,Busy,WrEn=%b required 1100",
                     {bus.Start, bus.Rx_Ready, bus.Busy, bus.IMem_WrEn});
        end
        @(negedge CLK);
        Reset_n = 1'b1;
        repeat (10) @(negedge CLK);
        compared++;
        if (wrLog.size() != 1 || wrLog[0] !== {8'h60, 9'h105}) begin
            mismatched++;
            $display("FAIL midreset_writes: log size %0d required 1 (105@60 only)", wrLog.size());
        end
        compared++;
        if ({bus.Start, bus.Busy} !== 2'b10) begin
            mismatched++;
            $display("FAIL midreset_idle: Start,Busy=%b required 10", {bus.Start, bus.Busy});
        end
    endtask

`ifdef CHECKSUM_EN
    task automatic test_checksum();
        send_byte(8'h01); send_byte(8'h20); send_byte(8'h05); send_byte(8'h00); send_byte(8'h25);
        compared++;
        if ({bus.Err, bus.Start, bus.Busy} !== 3'b110) begin
            mismatched++;
            $display("FAIL csum_bad: Err,Start,Busy=%b required 110", {bus.Err, bus.Start, bus.Busy});
        end
        send_byte(8'h01);
        compared++;
        if (bus.Err !== 1'b1) begin
            mismatched++;
            $display("FAIL csum_sticky: Err=%b required 1", bus.Err);
        end
        send_byte(8'h20); send_byte(8'h05); send_byte(8'h00); send_byte(8'h24);
        wait_launch();
        compared++;
        if ({bus.Err, bus.Start_Addr} !== {1'b0, 8'h20}) begin
            mismatched++;
            $display("FAIL csum_good: Err=%b Start_Addr=%h required 0/20", bus.Err, bus.Start_Addr);
        end
        pulse_done();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_held_zero();
        test_reset_mid();
`ifdef CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
